// File: rtl/div_frec_pkg.sv
// ----------------------------------------------------------------------------
// div_frec_pkg : shared divider helpers (ratio, counter width, half period)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package div_frec_pkg;

    localparam int C_MIN_DIV = 2;

    function automatic int div_of(input int clk_hz, input int freq);
        return clk_hz / freq;
    endfunction

    function automatic int cw_of(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    // Floor of half the period: the low phase length of the square wave.
    function automatic int half_of(input int div);
        return div / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_frec_multi_if.sv
// ----------------------------------------------------------------------------
// div_frec_multi_if : per-channel enable/clear/tick(/sq) bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface div_frec_multi_if #(
    parameter int CH = 2
);
    logic [CH-1:0] en;
    logic [CH-1:0] clr;
    logic [CH-1:0] tick;
`ifdef DIV_FREC_SQUARE_OUT_EN
    logic [CH-1:0] sq;

    modport master (output en, output clr, input tick, input sq);
    modport slave  (input en, input clr, output tick, output sq);
`else
    modport master (output en, output clr, input tick);
    modport slave  (input en, input clr, output tick);
`endif
endinterface

`default_nettype wire

// File: rtl/div_frec_ch.sv
// ----------------------------------------------------------------------------
// div_frec_ch : one divider channel, counter + tick (+ sq with DIV_FREC_SQUARE_OUT_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_frec_ch
    import div_frec_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clkIn,
    input  logic rstN,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
`ifdef DIV_FREC_SQUARE_OUT_EN
    ,
    output logic sq_o
`endif
);

    localparam int              CW        = cw_of(DIV);
    localparam int              H         = half_of(DIV);
    localparam logic [CW-1:0]   C_LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0]   C_HALF_M1 = CW'(H - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          at_last;

    assign at_last = (cnt_q == C_LAST);

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d  = at_last ? '0 : cnt_q + CW'(1);
            tick_d = at_last;
        end
    end

    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

`ifdef DIV_FREC_SQUARE_OUT_EN
    logic sq_q, sq_d;

    // Falls on the wrap edge so the falling edge lines up with the tick.
    always_comb begin
        sq_d = sq_q;
        if (clr_i) begin
            sq_d = 1'b0;
        end else if (en_i) begin
            if (at_last) begin
                sq_d = 1'b0;
            end else if (cnt_q == C_HALF_M1) begin
                sq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_o = sq_q;
`endif

endmodule

`default_nettype wire

// File: rtl/div_frec_multi.sv
// ----------------------------------------------------------------------------
// div_frec_multi : CH independent clock-enable dividers, DIV = CLK_HZ / FREQ
// Optional square-wave outputs: define DIV_FREC_SQUARE_OUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_frec_multi
    import div_frec_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int FREQ   = 60,
    parameter int CH     = 2
) (
    input  logic             clkIn,
    input  logic             rstN,
    div_frec_multi_if.slave  bus
);

    localparam int DIV = div_of(CLK_HZ, FREQ);

    if (DIV < C_MIN_DIV) begin : g_div_chk
        $fatal(1, "div_frec_multi: DIV=%0d must be at least 2", DIV);
    end

    if (CH < 1) begin : g_ch_chk
        $fatal(1, "div_frec_multi: CH=%0d must be at least 1", CH);
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        div_frec_ch #(
            .DIV (DIV)
        ) u_ch (
            .clkIn  (clkIn),
            .rstN   (rstN),
            .en_i   (bus.en[i]),
            .clr_i  (bus.clr[i]),
            .tick_o (bus.tick[i])
`ifdef DIV_FREC_SQUARE_OUT_EN
            ,
            .sq_o   (bus.sq[i])
`endif
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_div_frec_multi.sv
// ----------------------------------------------------------------------------
// tb_div_frec_multi : directed checks for DIV=10 (CH=2) and DIV=7 (CH=1)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_div_frec_multi;

    logic clkIn = 1'b0;
    logic rstN  = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int p0, p1, p7;
    int lat;

    div_frec_multi_if #(.CH(2)) bus10 ();
    div_frec_multi_if #(.CH(1)) bus7  ();

    div_frec_multi #(.CLK_HZ(100), .FREQ(10), .CH(2)) u_dut10 (
        .clkIn (clkIn),
        .rstN  (rstN),
        .bus   (bus10.slave)
    );

    div_frec_multi #(.CLK_HZ(70), .FREQ(10), .CH(1)) u_dut7 (
        .clkIn (clkIn),
        .rstN  (rstN),
        .bus   (bus7.slave)
    );

    always #5 clkIn = ~clkIn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clkIn);
        #1;
    endtask

    // p* = enabled edges since the phase origin; tick on every 10th (7th) one.
    task automatic cyc(input logic [1:0] en_v, input logic [1:0] clr_v, input logic en7);
        logic [1:0] et, es;
        logic       adv0, adv1;
        bus10.en  = en_v;
        bus10.clr = clr_v;
        bus7.en   = en7;
        bus7.clr  = 1'b0;
        step();
        adv0 = 1'b0;
        adv1 = 1'b0;
        if (clr_v[0]) p0 = 0; else if (en_v[0]) begin p0++; adv0 = 1'b1; end
        if (clr_v[1]) p1 = 0; else if (en_v[1]) begin p1++; adv1 = 1'b1; end
        et = {adv1 && (p1 % 10 == 0), adv0 && (p0 % 10 == 0)};
        es = {(p1 % 10) >= 5, (p0 % 10) >= 5};
        chk("tick10", 32'(bus10.tick), 32'(et));
`ifdef DIV_FREC_SQUARE_OUT_EN
        chk("sq10", 32'(bus10.sq), 32'(es));
`endif
        if (en7) begin
            p7++;
            chk("tick7", 32'(bus7.tick), 32'(p7 % 7 == 0));
`ifdef DIV_FREC_SQUARE_OUT_EN
            chk("sq7", 32'(bus7.sq), 32'((p7 % 7) >= 3));
`endif
        end
    endtask

    task automatic do_reset();
        rstN      = 1'b0;
        bus10.en  = 2'b00;
        bus10.clr = 2'b00;
        bus7.en   = 1'b0;
        bus7.clr  = 1'b0;
        step();
        step();
        chk("rst_tick10", 32'(bus10.tick), 32'd0);
        chk("rst_tick7", 32'(bus7.tick), 32'd0);
`ifdef DIV_FREC_SQUARE_OUT_EN
        chk("rst_sq10", 32'(bus10.sq), 32'd0);
        chk("rst_sq7", 32'(bus7.sq), 32'd0);
`endif
        rstN = 1'b1;
        p0 = 0;
        p1 = 0;
        p7 = 0;
    endtask

    initial begin
        // Steady run: ticks after edge 10, 20, 30 (DIV=10) and every 7 (DIV=7).
        do_reset();
        for (int k = 0; k < 30; k++) cyc(2'b11, 2'b00, 1'b1);

        // Hold channel 0 at cnt=4, resume: 6 more edges to the tick.
        do_reset();
        repeat (4) cyc(2'b11, 2'b00, 1'b0);
        repeat (20) cyc(2'b10, 2'b00, 1'b0);
        lat = 0;
        for (int j = 1; j <= 13; j++) begin
            cyc(2'b11, 2'b00, 1'b0);
            if (lat == 0 && bus10.tick[0]) lat = j;
        end
        chk("hold_lat", 32'(lat), 32'd6);

        // Channel 0 is at cnt=7; clear with en high, tick 10 edges later.
        cyc(2'b11, 2'b01, 1'b0);
        lat = 0;
        for (int m = 1; m <= 12; m++) begin
            cyc(2'b11, 2'b00, 1'b0);
            if (lat == 0 && bus10.tick[0]) lat = m;
        end
        chk("clr_lat", 32'(lat), 32'd10);

        // Async reset at cnt=9, between clock edges.
        do_reset();
        repeat (9) cyc(2'b11, 2'b00, 1'b0);
        #3 rstN = 1'b0;
        #1;
        chk("arst_tick", 32'(bus10.tick), 32'd0);
`ifdef DIV_FREC_SQUARE_OUT_EN
        chk("arst_sq", 32'(bus10.sq), 32'd0);
`endif
        step();
        chk("arst_hold", 32'(bus10.tick), 32'd0);
        rstN = 1'b1;
        p0 = 0;
        p1 = 0;
        lat = 0;
        for (int j = 1; j <= 12; j++) begin
            cyc(2'b11, 2'b00, 1'b0);
            if (lat == 0 && bus10.tick[0]) lat = j;
        end
        chk("arst_lat", 32'(lat), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
